bit_reduction_accumulator: RTL and testbench

Streaming front end for Boolean bit reduction. Accepts a packet of `WORD_WIDTH`-bit words over a valid/ready handshake. Folds every bit of every beat into one true chained reduction (`OPERATION`), in order from beat 0 bit 0 upward. Presents the single-bit result, plus the packet's beat count, on a registered valid/ready output; it sits upstream of condition-decode and status logic that needs a reduction over more bits than one bus word carries.

---
 rtl/bit_reduction_accumulator_pkg.sv | 60 ++++++
 rtl/bit_reduction_accumulator_bit_reducer.sv | 20 ++
 rtl/bit_reduction_accumulator.sv | 106 ++++++++++
 tb/tb_bit_reduction_accumulator.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bit_reduction_accumulator_pkg.sv
// Shared definitions for the bit reduction accumulator: operation decode,
// single-step Boolean operators and a saturating increment for counters.
package bit_reduction_accumulator_pkg;

    typedef enum logic [2:0] {
        OP_AND,
        OP_NAND,
        OP_OR,
        OP_NOR,
        OP_XOR,
        OP_XNOR,
        OP_NONE
    } op_t;

    typedef enum logic {
        ST_ACCEPT,
        ST_HOLD
    } state_t;

    localparam logic [63:0] NAME_AND  = 64'("AND");
    localparam logic [63:0] NAME_NAND = 64'("NAND");
    localparam logic [63:0] NAME_OR   = 64'("OR");
    localparam logic [63:0] NAME_NOR  = 64'("NOR");
    localparam logic [63:0] NAME_XOR  = 64'("XOR");
    localparam logic [63:0] NAME_XNOR = 64'("XNOR");

    // Names are right-justified string literals, so shorter names compare equal
    // once zero-extended to 64 bits.
    function automatic op_t decode_op(input logic [63:0] name);
        case (name)
            NAME_AND:  return OP_AND;
            NAME_NAND: return OP_NAND;
            NAME_OR:   return OP_OR;
            NAME_NOR:  return OP_NOR;
            NAME_XOR:  return OP_XOR;
            NAME_XNOR: return OP_XNOR;
            default:   return OP_NONE;
        endcase
    endfunction

    function automatic logic apply_op(input op_t op, input logic a, input logic b);
        case (op)
            OP_AND:  return a & b;
            OP_NAND: return ~(a & b);
            OP_OR:   return a | b;
            OP_NOR:  return ~(a | b);
            OP_XOR:  return a ^ b;
            OP_XNOR: return ~(a ^ b);
            default: return 1'b0;
        endcase
    endfunction

    // Increment that sticks at the all-ones value of a counter 'width' bits wide.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
        logic [31:0] max;
        max = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
        return (value >= max) ? max : value + 32'd1;
    endfunction

endpackage

// File: rtl/bit_reduction_accumulator_bit_reducer.sv
// Chained bit reducer: r0 = data[0], rk = op(rk-1, data[k]); inverting
// operators re-invert at every step.
module bit_reduction_accumulator_bit_reducer
    import bit_reduction_accumulator_pkg::*;
#(
    parameter int  WIDTH = 1,
    parameter op_t OP    = OP_XOR
) (
    input  logic [WIDTH-1:0] data,
    output logic             result
);

    always_comb begin
        result = data[0];
        for (int k = 1; k < WIDTH; k++) begin
            result = apply_op(OP, result, data[k]);
        end
    end

endmodule

// File: rtl/bit_reduction_accumulator.sv
// Streaming packet bit reduction with registered valid/ready result.
// Beat counter and output_count are built only when BIT_REDUCTION_ACCUMULATOR_COUNT_EN is defined.
module bit_reduction_accumulator
    import bit_reduction_accumulator_pkg::*;
#(
    parameter            OPERATION   = "",
    parameter int        WORD_WIDTH  = 0,
    parameter int        COUNT_WIDTH = 8,
    localparam int       W           = (WORD_WIDTH < 1) ? 1 : WORD_WIDTH
) (
    input  logic                   clock,
    input  logic                   clear_n,
    input  logic                   input_valid,
    output logic                   input_ready,
    input  logic [W-1:0]           input_data,
    input  logic                   input_last,
    output logic                   output_valid,
    input  logic                   output_ready,
    output logic                   output_bit,
    output logic [COUNT_WIDTH-1:0] output_count
);

    localparam op_t  OP    = decode_op(64'(OPERATION));
    localparam logic OP_OK = (OP != OP_NONE);

    state_t state;
    logic   acc;
    logic   first;
    logic   first_result;
    logic   cont_result;
    logic   beat_result;
    logic   in_fire;
    logic   out_fire;

    assign output_valid = (state == ST_HOLD);
    assign input_ready  = clear_n & (~output_valid | output_ready);
    assign in_fire      = input_valid & input_ready;
    assign out_fire     = output_valid & output_ready;

    bit_reduction_accumulator_bit_reducer #(
        .WIDTH (W),
        .OP    (OP)
    ) u_first_reducer (
        .data   (input_data),
        .result (first_result)
    );

    // Continuation beats fold the running result in ahead of the new word's bit 0.
    bit_reduction_accumulator_bit_reducer #(
        .WIDTH (W + 1),
        .OP    (OP)
    ) u_cont_reducer (
        .data   ({input_data, acc}),
        .result (cont_result)
    );

    assign beat_result = OP_OK ? (first ? first_result : cont_result) : 1'b0;

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state      <= ST_ACCEPT;
            output_bit <= 1'b0;
            acc        <= 1'b0;
            first      <= 1'b1;
        end else begin
            if (in_fire) begin
                if (input_last) begin
                    output_bit <= beat_result;
                    first      <= 1'b1;
                end else begin
                    acc   <= beat_result;
                    first <= 1'b0;
                end
            end
            // A new last beat arriving alongside the output handshake keeps us in HOLD.
            case (state)
                ST_ACCEPT: if (in_fire && input_last) state <= ST_HOLD;
                ST_HOLD:   if (out_fire && !(in_fire && input_last)) state <= ST_ACCEPT;
            endcase
        end
    end

`ifdef BIT_REDUCTION_ACCUMULATOR_COUNT_EN
    logic [COUNT_WIDTH-1:0] count;
    logic [COUNT_WIDTH-1:0] count_next;

    assign count_next = COUNT_WIDTH'(sat_inc(32'(count), COUNT_WIDTH));

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            count        <= '0;
            output_count <= '0;
        end else if (in_fire) begin
            if (input_last) begin
                output_count <= count_next;
                count        <= '0;
            end else begin
                count <= count_next;
            end
        end
    end
`else
    assign output_count = '0;
`endif

endmodule

// File: tb/tb_bit_reduction_accumulator.sv
// Bench for bit_reduction_accumulator: eight instances share one stimulus stream
// (all six operators, an unrecognised name, and a 2-bit counter variant).
module tb_bit_reduction_accumulator;

    localparam int N = 8;
    localparam logic [63:0] OPS [7] = '{"AND", "NAND", "OR", "NOR", "XOR", "XNOR", "BOGUS"};

    logic       clock = 1'b0;
    logic       clear_n = 1'b1;
    logic       input_valid = 1'b0;
    logic [3:0] input_data = 4'h0;
    logic       input_last = 1'b0;
    logic       output_ready = 1'b0;

    logic       irdy [N];
    logic       ovld [N];
    logic       obit [N];
    logic [7:0] ocnt [7];
    logic [1:0] ocnt_w2;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic mvalid = 1'b0;
    logic mpkt [$];
    int   mbeats = 0;
    logic mres [N];
    int   mcnt = 0;

    always #5 clock = ~clock;

    for (genvar g = 0; g < 7; g++) begin : g_op
        bit_reduction_accumulator #(
            .OPERATION   (OPS[g]),
            .WORD_WIDTH  (4),
            .COUNT_WIDTH (8)
        ) u_dut (
            .clock        (clock),
            .clear_n      (clear_n),
            .input_valid  (input_valid),
            .input_ready  (irdy[g]),
            .input_data   (input_data),
            .input_last   (input_last),
            .output_valid (ovld[g]),
            .output_ready (output_ready),
            .output_bit   (obit[g]),
            .output_count (ocnt[g])
        );
    end

    bit_reduction_accumulator #(
        .OPERATION   ("XOR"),
        .WORD_WIDTH  (4),
        .COUNT_WIDTH (2)
    ) u_dut_w2 (
        .clock        (clock),
        .clear_n      (clear_n),
        .input_valid  (input_valid),
        .input_ready  (irdy[7]),
        .input_data   (input_data),
        .input_last   (input_last),
        .output_valid (ovld[7]),
        .output_ready (output_ready),
        .output_bit   (obit[7]),
        .output_count (ocnt_w2)
    );

    typedef struct {
        logic       iv;
        logic [3:0] d;
        logic       il;
        logic       ordy;
        logic       ev;
        int         inst;
        logic       eb;
        int         ec;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t mk(logic iv, logic [3:0] d, logic il, logic ordy,
                                logic ev, int inst, logic eb, int ec);
        vec_t v;
        v.iv = iv; v.d = d; v.il = il; v.ordy = ordy;
        v.ev = ev; v.inst = inst; v.eb = eb; v.ec = ec;
        return v;
    endfunction

    function automatic int get_cnt(int i);
        return (i == 7) ? int'(ocnt_w2) : int'(ocnt[i]);
    endfunction

    function automatic int exp_cnt(int i, int raw);
`ifdef BIT_REDUCTION_ACCUMULATOR_COUNT_EN
        int lim;
        lim = (i == 7) ? 3 : 255;
        return (raw > lim) ? lim : raw;
`else
        return 0;
`endif
    endfunction

    // Fold the whole packet's bit sequence with the instance's operator.
    function automatic logic ref_bit(int i);
        int   opc;
        logic r;
        opc = (i == 7) ? 4 : i;
        if (opc == 6) return 1'b0;
        r = mpkt[0];
        for (int k = 1; k < mpkt.size(); k++) begin
            case (opc)
                0: r = r & mpkt[k];
                1: r = !(r && mpkt[k]);
                2: r = r | mpkt[k];
                3: r = !(r || mpkt[k]);
                4: r = r ^ mpkt[k];
                default: r = (r == mpkt[k]);
            endcase
        end
        return r;
    endfunction

    task automatic check(string name, int i, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0d, expected %0d", name, i, act, exp);
        end
    endtask

    task automatic model_edge();
        logic ready;
        logic fire_in;
        logic fire_out;
        ready    = !mvalid || output_ready;
        fire_in  = input_valid && ready;
        fire_out = mvalid && output_ready;
        if (fire_in) begin
            for (int k = 0; k < 4; k++) mpkt.push_back(input_data[k]);
            mbeats++;
        end
        if (fire_in && input_last) begin
            for (int i = 0; i < N; i++) mres[i] = ref_bit(i);
            mcnt   = mbeats;
            mvalid = 1'b1;
            mpkt.delete();
            mbeats = 0;
        end else if (fire_out) begin
            mvalid = 1'b0;
        end
    endtask

    task automatic check_ready();
        for (int i = 0; i < N; i++)
            check("input_ready", i, int'(irdy[i]), int'(!mvalid || output_ready));
    endtask

    task automatic check_outputs();
        for (int i = 0; i < N; i++) begin
            check("output_valid", i, int'(ovld[i]), int'(mvalid));
            if (mvalid) begin
                check("output_bit", i, int'(obit[i]), int'(mres[i]));
                check("output_count", i, get_cnt(i), exp_cnt(i, mcnt));
            end
        end
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic cycle(logic iv, logic [3:0] d, logic il, logic ordy);
        input_valid  = iv;
        input_data   = d;
        input_last   = il;
        output_ready = ordy;
        #1;
        check_ready();
        @(posedge clock);
        model_edge();
        @(negedge clock);
        check_outputs();
    endtask

    initial begin
        for (int i = 0; i < N; i++) mres[i] = 1'b0;

        // Reset state
        #2 clear_n = 1'b0;
        #1;
        for (int i = 0; i < N; i++) begin
            check("reset_valid", i, int'(ovld[i]), 0);
            check("reset_bit", i, int'(obit[i]), 0);
            check("reset_count", i, get_cnt(i), 0);
            check("reset_ready", i, int'(irdy[i]), 0);
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        clear_n = 1'b1;

        // Instances: 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6 unknown, 7 XOR/2-bit count
        tbl.push_back(mk(1, 4'b1011, 1, 0, 1, 4, 1, 1));
        tbl.push_back(mk(0, 4'h0,    0, 1, 0, 4, 0, 0));
        tbl.push_back(mk(1, 4'b0100, 1, 0, 1, 3, 1, 1));
        tbl.push_back(mk(0, 4'h0,    0, 1, 0, 3, 0, 0));
        tbl.push_back(mk(1, 4'b0000, 0, 0, 0, 3, 0, 0));
        tbl.push_back(mk(1, 4'b0100, 1, 0, 1, 3, 1, 2));
        tbl.push_back(mk(0, 4'h0,    0, 1, 0, 3, 0, 0));
        for (int rep = 0; rep < 2; rep++) begin
            tbl.push_back(mk(1, 4'hF, 0, 0, 0, 0, 0, 0));
            tbl.push_back(mk(0, 4'h0, 0, 0, 0, 0, 0, 0));
            tbl.push_back(mk(0, 4'h0, 0, 0, 0, 0, 0, 0));
            tbl.push_back(mk(1, 4'hF, 0, 0, 0, 0, 0, 0));
            tbl.push_back(mk(0, 4'h0, 0, 0, 0, 0, 0, 0));
            tbl.push_back(mk(0, 4'h0, 0, 0, 0, 0, 0, 0));
            if (rep == 0) begin
                tbl.push_back(mk(1, 4'hE, 1, 0, 1, 0, 0, 3));
                tbl.push_back(mk(0, 4'h0, 0, 1, 0, 0, 0, 0));
            end else begin
                tbl.push_back(mk(1, 4'hF, 1, 0, 1, 0, 1, 3));
            end
        end
        // Backpressure: offered last beat must wait, result must hold
        for (int k = 0; k < 3; k++) tbl.push_back(mk(1, 4'hE, 1, 0, 1, 0, 1, 3));
        tbl.push_back(mk(1, 4'hE, 1, 1, 1, 0, 0, 1));
        tbl.push_back(mk(0, 4'h0, 0, 1, 0, 0, 0, 0));
        // Saturation on the 2-bit counter
        for (int k = 0; k < 4; k++) tbl.push_back(mk(1, 4'h1, 0, 0, 0, 7, 0, 0));
        tbl.push_back(mk(1, 4'h1, 1, 0, 1, 7, 1, 3));
        tbl.push_back(mk(0, 4'h0, 0, 1, 0, 7, 0, 0));
        tbl.push_back(mk(1, 4'hF, 1, 0, 1, 6, 0, 1));
        tbl.push_back(mk(0, 4'h0, 0, 1, 0, 6, 0, 0));

        foreach (tbl[r]) begin
            cycle(tbl[r].iv, tbl[r].d, tbl[r].il, tbl[r].ordy);
            check("vec_valid", r, int'(ovld[tbl[r].inst]), int'(tbl[r].ev));
            if (tbl[r].ev) begin
                check("vec_bit", r, int'(obit[tbl[r].inst]), int'(tbl[r].eb));
`ifdef BIT_REDUCTION_ACCUMULATOR_COUNT_EN
                check("vec_count", r, get_cnt(tbl[r].inst), tbl[r].ec);
`else
                check("vec_count", r, get_cnt(tbl[r].inst), 0);
`endif
            end
        end

        // Reset in the middle of a packet, released before the next edge
        cycle(1, 4'h3, 0, 0);
        cycle(1, 4'h5, 0, 0);
        input_valid = 1'b0;
        #1 clear_n = 1'b0;
        #1;
        for (int i = 0; i < N; i++) begin
            check("midrst_valid", i, int'(ovld[i]), 0);
            check("midrst_bit", i, int'(obit[i]), 0);
            check("midrst_count", i, get_cnt(i), 0);
            check("midrst_ready", i, int'(irdy[i]), 0);
        end
        #1 clear_n = 1'b1;
        mvalid = 1'b0;
        mpkt.delete();
        mbeats = 0;
        @(negedge clock);
        cycle(1, 4'b0111, 1, 0);
        check("post_rst_bit", 4, int'(obit[4]), 1);
        check("post_rst_count", 4, get_cnt(4), exp_cnt(4, 1));
        cycle(0, 4'h0, 0, 1);

        // Randomised traffic against the reference model
        for (int n = 0; n < 600; n++) begin
            cycle($urandom_range(0, 3) != 0, 4'($urandom), $urandom_range(0, 4) == 0,
                  $urandom_range(0, 1) == 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
